// File: rtl/option_feeder.sv
// option_feeder: producer side of the solver option stream.
// The candidate options for every line live in a recirculating FIFO, and each line is
// sent as one index word followed by that line's options. After each option the
// feeder waits for the solver's keep/drop verdict. A kept option goes back to the
// FIFO tail. The option count each line had in the previous pass is published on
// old_options_amnt.
// Optional macro STALL_DETECT_EN: adds the STUCK state and the stuck output. The feeder
// enters STUCK when a whole pass completes without any drop.
module option_feeder #(
    parameter int MAX_ROWS   = 3,
    parameter int MAX_COLS   = 3,
    parameter int SIZE       = 3,
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_W      = 7,
    localparam int NUM_LINES = MAX_ROWS + MAX_COLS,
    localparam int LINE_W    = $clog2(NUM_LINES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    input  logic                       load_is_index,
    input  logic [SIZE-1:0]            load_data,
    output logic                       load_ready,
    input  logic                       load_done,
    output logic                       out_valid,
    output logic                       out_is_index,
    output logic [SIZE-1:0]            out_option,
    input  logic                       out_ready,
    input  logic                       fb_valid,
    input  logic                       fb_keep,
    input  logic                       solved,
    output logic [NUM_LINES*CNT_W-1:0] old_options_amnt,
    output logic                       running,
`ifdef STALL_DETECT_EN
    output logic                       stuck,
`endif
    output logic                       done
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FILL_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT_FB = 3'd3,
`ifdef STALL_DETECT_EN
        S_STUCK   = 3'd5,
`endif
        S_DONE    = 3'd4
    } state_t;

    state_t state_reg, state_next;

    // FIFO storage: entry = {is_index, data}
    logic [SIZE:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [FILL_W-1:0]   fill_reg;
    logic [SIZE:0]       head_reg;
    logic                fifo_empty, fifo_full;

    logic                push, pop;
    logic [SIZE:0]       push_word;
    logic [SIZE-1:0]     opt_hold_reg;
    logic [LINE_W-1:0]   cur_line_reg;
    logic                head_is_index;
    logic [LINE_W-1:0]   head_line;
    logic                load_fire, fb_fire, keep_fire;
    logic                cnt_inc, cnt_clear;

`ifdef STALL_DETECT_EN
    logic                first_pass_reg, drop_seen_reg;
    logic                drop_fire, pass_boundary, stall_hit;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_empty    = (fill_reg == '0);
    assign fifo_full     = (fill_reg == FILL_W'(FIFO_DEPTH));
    assign head_is_index = head_reg[SIZE];
    assign head_line     = head_reg[LINE_W-1:0];

    // Handshake strobes. While solved is high nothing moves, so a pending verdict is discarded.
    always_comb begin
        load_fire = (state_reg == S_LOAD) && load_valid && !fifo_full;
        pop       = (state_reg == S_ISSUE) && !fifo_empty && out_ready && !solved;
        fb_fire   = (state_reg == S_WAIT_FB) && fb_valid && !solved;
        keep_fire = fb_fire && fb_keep;
        // Index words always recirculate; options only when kept
        push      = load_fire || (pop && head_is_index) || keep_fire;
        if (load_fire)
            push_word = {load_is_index,
                         load_is_index ? SIZE'(load_data[LINE_W-1:0]) : load_data};
        else if (pop)
            push_word = head_reg;
        else
            push_word = {1'b0, opt_hold_reg};
        cnt_inc     = (load_fire && !load_is_index) || keep_fire;
        cnt_clear   = pop && head_is_index;
        rd_ptr_next = pop ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    end

`ifdef STALL_DETECT_EN
    // Popping the index of line 0 closes one pass and opens the next
    always_comb begin
        drop_fire     = fb_fire && !fb_keep;
        pass_boundary = cnt_clear && (head_line == '0);
        stall_hit     = pass_boundary && !first_pass_reg && !drop_seen_reg;
    end

    // Drop tracking per pass. The boundary that opens the first pass has nothing to judge.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_pass_reg <= 1'b1;
            drop_seen_reg  <= 1'b0;
        end else if (state_reg == S_LOAD) begin
            first_pass_reg <= 1'b1;
            drop_seen_reg  <= 1'b0;
        end else if (pass_boundary) begin
            first_pass_reg <= 1'b0;
            drop_seen_reg  <= 1'b0;
        end else if (drop_fire) begin
            drop_seen_reg  <= 1'b1;
        end
    end
`endif

    // FIFO pointers and occupancy. A simultaneous pop and push leaves the fill unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            rd_ptr_reg <= rd_ptr_next;
            case ({push, pop})
                2'b10:   fill_reg <= fill_reg + 1'b1;
                2'b01:   fill_reg <= fill_reg - 1'b1;
                default: fill_reg <= fill_reg;
            endcase
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= push_word;
    end

    // Registered head read at the next read pointer. The bypass covers a word pushed
    // into a FIFO that would otherwise be empty.
    always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == rd_ptr_next))
            head_reg <= push_word;
        else
            head_reg <= mem[rd_ptr_next];
    end

    // Holds the option awaiting a verdict, and the line whose counter is being built
    always_ff @(posedge clk) begin
        if (rst) begin
            opt_hold_reg <= '0;
            cur_line_reg <= '0;
        end else begin
            if (pop)
                opt_hold_reg <= head_reg[SIZE-1:0];
            if (load_fire && load_is_index)
                cur_line_reg <= load_data[LINE_W-1:0];
            else if (cnt_clear)
                cur_line_reg <= head_line;
        end
    end

    // Per-line live counter and published previous-pass count
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
            logic [CNT_W-1:0] live_cnt_reg;
            logic [CNT_W-1:0] old_cnt_reg;

            // Snapshot and clear on this line's index pop; saturating increment on a new option
            always_ff @(posedge clk) begin
                if (rst) begin
                    live_cnt_reg <= '0;
                    old_cnt_reg  <= '0;
                end else if (cnt_clear && (head_line == LINE_W'(gi))) begin
                    old_cnt_reg  <= live_cnt_reg;
                    live_cnt_reg <= '0;
                end else if (cnt_inc && (cur_line_reg == LINE_W'(gi)) && (live_cnt_reg != '1)) begin
                    live_cnt_reg <= live_cnt_reg + 1'b1;
                end
            end

            assign old_options_amnt[gi*CNT_W +: CNT_W] = old_cnt_reg;
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    state_next = S_LOAD;
            S_LOAD:    if (load_done) state_next = S_ISSUE;
            S_ISSUE: begin
                if (solved)
                    state_next = S_DONE;
`ifdef STALL_DETECT_EN
                else if (stall_hit)
                    state_next = S_STUCK;
`endif
                else if (pop && !head_is_index)
                    state_next = S_WAIT_FB;
            end
            S_WAIT_FB: begin
                if (solved)
                    state_next = S_DONE;
                else if (fb_valid)
                    state_next = S_ISSUE;
            end
            S_DONE:    state_next = S_DONE;
`ifdef STALL_DETECT_EN
            S_STUCK:   state_next = S_STUCK;
`endif
            default:   state_next = S_IDLE;
        endcase
    end

    // Output decode. The FIFO head is shown only while issuing.
    always_comb begin
        out_valid    = (state_reg == S_ISSUE) && !fifo_empty;
        out_is_index = out_valid && head_is_index;
        out_option   = out_valid ? head_reg[SIZE-1:0] : '0;
        load_ready   = (state_reg == S_LOAD) && !fifo_full;
        running      = (state_reg == S_ISSUE) || (state_reg == S_WAIT_FB);
        done         = (state_reg == S_DONE);
`ifdef STALL_DETECT_EN
        stuck        = (state_reg == S_STUCK);
`endif
    end

endmodule
